// File: rtl/uart_frame_scheduler_pkg.sv
// Shared definitions for the UART frame scheduler: FSM state encoding,
// default header byte and the frame-length helper.
// Optional feature macro: UART_FRAME_CHECKSUM_EN (appends an XOR checksum byte).
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sched_state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  // Width of channel ids and byte indices (up to 8 channels, up to 7 bytes).
  localparam int IDX_W = 3;

  // Number of bytes in one frame for a given requester word width.
  function automatic int nbytes(input int word_w);
`ifdef UART_FRAME_CHECKSUM_EN
    return 3 + word_w / 8;
`else
    return 2 + word_w / 8;
`endif
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Byte-level handshake between the frame scheduler (master) and the UART
// transmitter (slave).
interface uart_frame_scheduler_if;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting;
  logic       uart_tx_done;

  modport master (
    output uart_transmit,
    output uart_tx_byte,
    input  uart_is_transmitting,
    input  uart_tx_done
  );

  modport slave (
    input  uart_transmit,
    input  uart_tx_byte,
    output uart_is_transmitting,
    output uart_tx_done
  );
endinterface

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr_i,
// wrapping from NUM_REQ-1 back to 0. Holds no state; the scheduler owns ptr.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IDX_W-1:0]   winner_idx_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     rot_pos;
  logic [IDX_W:0]       idx_sum;

  // Rotate requests so ptr sits at bit 0, find the lowest set bit, then
  // rotate the position back into channel numbering.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[ptr_i +: NUM_REQ];
    rot_pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rot_pos = IDX_W'(k);
      end
    end
    idx_sum = {1'b0, ptr_i} + {1'b0, rot_pos};
    if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
    end
    winner_idx_o = idx_sum[IDX_W-1:0];
    valid_o      = |req_i;
    winner_oh_o  = valid_o ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << winner_idx_o) : '0;
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Round-robin frame scheduler sharing one UART transmitter among NUM_REQ
// requesters. Each frame: header, channel id, word bytes MSB first and,
// when UART_FRAME_CHECKSUM_EN is defined, an XOR checksum of all prior bytes.
// All outputs are registered.
module uart_frame_scheduler
  import uart_sched_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter int         WORD_W      = 16,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      frame_done,
  uart_frame_scheduler_if.master    uart
);

  localparam int WB = WORD_W / 8;
  localparam int NB = nbytes(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] DATA_END = IDX_W'(2 + WB);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_REQ - 1);

  sched_state_t         state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     byte_idx_q;
  logic [IDX_W-1:0]     chan_q;
  logic [WORD_W-1:0]    word_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 transmit_q;
  logic [7:0]           tx_byte_q;

  logic                 arb_valid;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic [WORD_W-1:0]    word_d;
  logic [7:0]           cur_byte_d;
  logic [5:0]           data_shift;
  logic [WORD_W-1:0]    word_shifted;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i        (req),
    .ptr_i        (rr_ptr_q),
    .valid_o      (arb_valid),
    .winner_oh_o  (arb_oh),
    .winner_idx_o (arb_idx)
  );

  // Word of the current arbitration winner, captured only on the grant edge.
  always_comb begin
    word_d = req_data[int'(arb_idx) * WORD_W +: WORD_W];
  end

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] checksum_d;

  // XOR of header, channel id and every word byte.
  always_comb begin
    checksum_d = HEADER_BYTE ^ {5'b0, chan_q};
    for (int k = 0; k < WB; k++) begin
      checksum_d = checksum_d ^ word_q[k*8 +: 8];
    end
  end
`endif

  // Select the frame byte addressed by byte_idx_q.
  always_comb begin
    data_shift   = {byte_idx_q - 3'd2, 3'b000};
    word_shifted = word_q << data_shift;
    cur_byte_d   = 8'h00;
    if (byte_idx_q == '0) begin
      cur_byte_d = HEADER_BYTE;
    end else if (byte_idx_q == IDX_W'(1)) begin
      cur_byte_d = {5'b0, chan_q};
    end else if (byte_idx_q < DATA_END) begin
      cur_byte_d = word_shifted[WORD_W-1 -: 8];
    end else begin
`ifdef UART_FRAME_CHECKSUM_EN
      cur_byte_d = checksum_d;
`else
      cur_byte_d = 8'h00;
`endif
    end
  end

  // Scheduler FSM: arbitrate in IDLE, issue one byte in SEND, await tx_done in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      byte_idx_q   <= '0;
      chan_q       <= '0;
      word_q       <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      transmit_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
    end else begin
      grant_q      <= '0;
      frame_done_q <= 1'b0;
      transmit_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            word_q     <= word_d;
            chan_q     <= arb_idx;
            grant_q    <= arb_oh;
            busy_q     <= 1'b1;
            byte_idx_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (!uart.uart_is_transmitting) begin
            transmit_q <= 1'b1;
            tx_byte_q  <= cur_byte_d;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (uart.uart_tx_done) begin
            if (byte_idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              rr_ptr_q     <= (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
              state_q      <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              state_q    <= SEND;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant              = grant_q;
  assign busy               = busy_q;
  assign frame_done         = frame_done_q;
  assign uart.uart_transmit = transmit_q;
  assign uart.uart_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Randomized bench for uart_frame_scheduler with a transaction-level model
// of arbitration, frame contents and handshake timing, plus a UART model
// (is_transmitting high from transmit until tx_done, tx_done 40 cycles later).
module tb_uart_frame_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WORD_W  = 16;
  localparam int WB      = WORD_W / 8;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = 3 + WB;
`else
  localparam int NB = 2 + WB;
`endif

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      frame_done;

  uart_frame_scheduler_if uif ();

  uart_frame_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .WORD_W      (WORD_W),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .busy       (busy),
    .frame_done (frame_done),
    .uart       (uif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model
  logic busy_r, done_r, force_busy, inject_done;
  int   uart_cnt;
  assign uif.uart_is_transmitting = busy_r | force_busy;
  assign uif.uart_tx_done         = done_r | inject_done;

  initial begin
    busy_r = 1'b0; done_r = 1'b0; uart_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      done_r = 1'b0;
      if (uart_cnt != 0) begin
        uart_cnt = uart_cnt - 1;
        if (uart_cnt == 0) begin
          done_r = 1'b1;
          busy_r = 1'b0;
        end
      end else if (uif.uart_transmit) begin
        busy_r   = 1'b1;
        uart_cnt = 40;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model state
  bit                        mon_en = 0;
  int                        m_ptr = 0;
  int                        m_chan = 0;
  bit                        active = 0, in_send = 0, send_next = 0, inflight = 0;
  bit                        exp_grant = 0, exp_tx = 0, exp_fd = 0, nfd;
  logic [NUM_REQ-1:0]        req_prev = '0;
  logic [NUM_REQ*WORD_W-1:0] data_prev = '0;
  logic [7:0]                exp_bytes[$];
  int                        grant_log[$];
  logic [7:0]                byte_log[$];
  int                        fd_count = 0;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (ptr + k) % NUM_REQ;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  // Compare process: every cycle, outputs against model expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (send_next) begin
        in_send   = 1;
        send_next = 0;
      end
      chk("grant_timing", 32'(grant != '0), 32'(exp_grant));
      chk("transmit_timing", 32'(uif.uart_transmit), 32'(exp_tx));
      chk("frame_done_timing", 32'(frame_done), 32'(exp_fd));
      if (grant != '0) begin
        int w;
        logic [WORD_W-1:0] wd;
        logic [7:0] cs;
        w  = rr_pick(req_prev, m_ptr);
        chk("grant_vec", 32'(grant), 32'(1) << w);
        wd = data_prev[w*WORD_W +: WORD_W];
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'(w));
        for (int b = WB - 1; b >= 0; b--) exp_bytes.push_back(wd[b*8 +: 8]);
`ifdef UART_FRAME_CHECKSUM_EN
        cs = 8'h00;
        foreach (exp_bytes[i]) cs = cs ^ exp_bytes[i];
        exp_bytes.push_back(cs);
`else
        cs = 8'h00;
`endif
        active  = 1;
        in_send = 1;
        m_chan  = w;
        grant_log.push_back(int'(grant));
      end
      if (uif.uart_transmit) begin
        if (exp_bytes.size() == 0) begin
          chk("tx_unexpected_byte", 32'(uif.uart_tx_byte), 32'hFFFF);
        end else begin
          chk("tx_byte", 32'(uif.uart_tx_byte), 32'(exp_bytes.pop_front()));
        end
        byte_log.push_back(uif.uart_tx_byte);
        in_send  = 0;
        inflight = 1;
      end
      nfd = 0;
      if (uif.uart_tx_done && inflight) begin
        inflight = 0;
        if (exp_bytes.size() == 0) nfd = 1;
        else send_next = 1;
      end
      if (frame_done) begin
        active = 0;
        m_ptr  = (m_chan + 1) % NUM_REQ;
        fd_count++;
        $display("frame_done ch=%0d time=%0t", m_chan, $time);
      end
      chk("busy", 32'(busy), 32'(active));
      exp_grant = !active && (req != '0);
      exp_tx    = in_send && !uif.uart_is_transmitting;
      exp_fd    = nfd;
      if (rst) begin
        m_ptr = 0; active = 0; in_send = 0; send_next = 0; inflight = 0;
        exp_grant = 0; exp_tx = 0; exp_fd = 0;
        exp_bytes.delete();
      end
      req_prev  = req;
      data_prev = req_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    byte_log.delete();
    fd_count = 0;
  endtask

  task automatic wait_fd(input int n, input int lim);
    int c = 0;
    while (fd_count < n && c < lim) begin
      tick();
      c++;
    end
    if (fd_count < n) chk("timeout_frame_done", 32'(fd_count), 32'(n));
  endtask

  task automatic wait_grants(input int n, input int lim);
    int c = 0;
    while (grant_log.size() < n && c < lim) begin
      tick();
      c++;
    end
    if (grant_log.size() < n) chk("timeout_grant", 32'(grant_log.size()), 32'(n));
  endtask

  task automatic check_bytes(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] e[5];
    e = '{e0, e1, e2, e3, e4};
    chk({nm, "_count"}, 32'(byte_log.size()), 32'(NB));
    for (int i = 0; i < NB && i < byte_log.size(); i++) begin
      chk($sformatf("%s_byte%0d", nm, i), 32'(byte_log[i]), 32'(e[i]));
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; force_busy = 1'b0; inject_done = 1'b0;
    repeat (3) tick();
    mon_en = 1;
    tick();
    rst = 1'b0;
    chk("reset_grant", 32'(grant), 0);
    chk("reset_transmit", 32'(uif.uart_transmit), 0);
    chk("reset_tx_byte", 32'(uif.uart_tx_byte), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_frame_done", 32'(frame_done), 0);

    // Single request on channel 2
    clear_logs();
    req_data[2*WORD_W +: WORD_W] = 16'h1234;
    req = 4'b0100;
    wait_grants(1, 50);
    req = '0;
    wait_fd(1, 400);
    tick();
    chk("single_grant_vec", 32'(grant_log.size() > 0 ? grant_log[0] : 0), 32'h4);
    chk("single_grant_count", 32'(grant_log.size()), 1);
    check_bytes("single", 8'hA5, 8'h02, 8'h12, 8'h34, 8'h81);
    chk("single_fd_count", 32'(fd_count), 1);
    chk("single_busy_after", 32'(busy), 0);

    // All four requesting from rr_ptr=0
    do_reset();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    req = 4'b1111;
    wait_grants(5, 2000);
    req = '0;
    wait_fd(5, 400);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_order_%0d", k), 32'(grant_log.size() > k ? grant_log[k] : 0),
          32'(1) << (k % NUM_REQ));
    end

    // Channel 1, data FF00 (checksum 5B when enabled)
    clear_logs();
    req_data[1*WORD_W +: WORD_W] = 16'hFF00;
    req = 4'b0010;
    wait_grants(1, 50);
    req = '0;
    wait_fd(1, 400);
    check_bytes("ch1_ff00", 8'hA5, 8'h01, 8'hFF, 8'h00, 8'h5B);

    // UART busy held while entering SEND
    clear_logs();
    force_busy = 1'b1;
    req_data[0 +: WORD_W] = 16'hBEEF;
    req = 4'b0001;
    wait_grants(1, 50);
    req = '0;
    repeat (10) tick();
    chk("held_no_transmit", 32'(byte_log.size()), 0);
    force_busy = 1'b0;
    tick();
    tick();
    chk("held_single_pulse", 32'(byte_log.size()), 1);
    wait_fd(1, 400);
    check_bytes("held", 8'hA5, 8'h00, 8'hBE, 8'hEF, 8'hA5 ^ 8'h00 ^ 8'hBE ^ 8'hEF);

    // Reset mid-frame after the second byte of channel 3
    clear_logs();
    req_data[3*WORD_W +: WORD_W] = 16'h5A5A;
    req = 4'b1000;
    wait_grants(1, 50);
    req = '0;
    begin
      int c = 0;
      while (byte_log.size() < 2 && c < 200) begin
        tick();
        c++;
      end
      chk("midframe_two_bytes", 32'(byte_log.size()), 2);
    end
    do_reset();
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_transmit", 32'(uif.uart_transmit), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    clear_logs();
    req_data[0 +: WORD_W] = 16'h0F0F;
    req = 4'b1001;
    wait_grants(1, 50);
    req = '0;
    wait_fd(1, 400);
    chk("post_rst_grant_ch0", 32'(grant_log.size() > 0 ? grant_log[0] : 0), 32'h1);
    chk("post_rst_first_byte", 32'(byte_log.size() > 0 ? byte_log[0] : 8'h00), 32'hA5);
    chk("post_rst_fd_count", 32'(fd_count), 1);

    // Stray tx_done while idle with no requests
    repeat (50) tick();
    clear_logs();
    inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    repeat (5) tick();
    chk("idle_done_no_tx", 32'(byte_log.size()), 0);
    chk("idle_done_no_fd", 32'(fd_count), 0);
    chk("idle_done_no_grant", 32'(grant_log.size()), 0);
    chk("idle_done_busy", 32'(busy), 0);

    // Random traffic; requests and data change freely, including while busy
    clear_logs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        req = NUM_REQ'($urandom);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
      end
      if ($urandom_range(0, 199) == 0) force_busy = ~force_busy;
      tick();
    end
    req = '0;
    force_busy = 1'b0;
    begin
      int c = 0;
      while (busy && c < 600) begin
        tick();
        c++;
      end
      chk("random_drain", 32'(busy), 0);
    end
    chk("random_progress", 32'(fd_count > 3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
